// File: rtl/axicb_id_order_ctrl.sv
// Per-ID AXI same-ID ordering and outstanding cap on a master address channel; zero-latency gating of valid/ready.
// Stalled requests see s_ready=0 until the owning slave retires them; optional stall timeout under AXICB_ORDER_TMO_EN.
module axicb_id_order_ctrl #(
  parameter int unsigned          AXI_ID_W    = 8,
  parameter int unsigned          SLV_NB      = 4,
  parameter int unsigned          NB_ID       = 4,
  parameter int unsigned          MAX_OSTD    = 4,
  parameter logic [AXI_ID_W-1:0]  MST_ID_MASK = '0,
  parameter int unsigned          TMO_W       = 16
) (
  input  logic                aclk,
  input  logic                srst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [AXI_ID_W-1:0] s_id,
  input  logic [SLV_NB-1:0]   s_ix,
  output logic                m_valid,
  input  logic                m_ready,
  input  logic                c_done,
  input  logic [AXI_ID_W-1:0] c_id,
  output logic                busy,
  output logic                err_uflow,
  output logic                err_tmo
);

  localparam int unsigned      IDX_W   = $clog2(NB_ID);
  localparam int unsigned      CNT_W   = $clog2(MAX_OSTD + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OSTD);

  logic [CNT_W-1:0]  cnt   [NB_ID];
  logic [SLV_NB-1:0] owner [NB_ID];

  logic [IDX_W-1:0] s_idx;
  logic [IDX_W-1:0] c_idx;
  logic             cnt_full;
  logic             owner_clash;
  logic             stall;
  logic             accept;
  logic             uflow_hit;
  logic [NB_ID-1:0] inc;
  logic [NB_ID-1:0] dec;
  logic [NB_ID-1:0] live;

  // Table index is the low bits of the ID once the master's own ID bits are removed.
  assign s_idx = IDX_W'(s_id ^ MST_ID_MASK);
  assign c_idx = IDX_W'(c_id ^ MST_ID_MASK);

  always_comb begin
    cnt_full    = (cnt[s_idx] == CNT_MAX);
    owner_clash = (cnt[s_idx] != '0) && (owner[s_idx] != s_ix);
    stall       = !srst && (cnt_full || owner_clash);
  end

  assign m_valid = s_valid && !stall;
  assign s_ready = m_ready && !stall;
  assign accept  = s_valid && s_ready;

  always_comb begin
    inc  = '0;
    dec  = '0;
    live = '0;
    for (int i = 0; i < NB_ID; i++) begin
      inc[i]  = accept && (s_idx == IDX_W'(i));
      dec[i]  = c_done && (c_idx == IDX_W'(i));
      live[i] = (cnt[i] != '0);
    end
    // A retire that coincides with an accept on the same ID cancels out and is not an underflow.
    uflow_hit = c_done && (cnt[c_idx] == '0) && !(accept && (s_idx == c_idx));
  end

  assign busy = |live;

  always_ff @(posedge aclk) begin
    if (srst) begin
      for (int i = 0; i < NB_ID; i++) begin
        cnt[i]   <= '0;
        owner[i] <= '0;
      end
      err_uflow <= 1'b0;
    end else begin
      for (int i = 0; i < NB_ID; i++) begin
        if (inc[i] && !dec[i]) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
          if (cnt[i] == '0) begin
            owner[i] <= s_ix;
          end
        end else if (dec[i] && !inc[i] && (cnt[i] != '0)) begin
          cnt[i] <= cnt[i] - CNT_W'(1);
        end
      end
      if (uflow_hit) begin
        err_uflow <= 1'b1;
      end
    end
  end

`ifdef AXICB_ORDER_TMO_EN
  localparam logic [TMO_W-1:0] TMO_SAT = '1;

  logic [TMO_W-1:0] tmo_cnt;
  logic [TMO_W-1:0] tmo_inc;
  logic             tmo_err;

  assign tmo_inc = tmo_cnt + TMO_W'(1);

  // Counts consecutive stalled-and-valid cycles; saturates and flags once it reaches all-ones.
  always_ff @(posedge aclk) begin
    if (srst) begin
      tmo_cnt <= '0;
      tmo_err <= 1'b0;
    end else if (s_valid && stall) begin
      if (tmo_cnt != TMO_SAT) begin
        tmo_cnt <= tmo_inc;
        if (tmo_inc == TMO_SAT) begin
          tmo_err <= 1'b1;
        end
      end
    end else begin
      tmo_cnt <= '0;
    end
  end

  assign err_tmo = tmo_err;
`else
  // No timeout tracking in this build; TMO_W only sizes the counter when it exists.
  assign err_tmo = 1'b0 & (TMO_W != 0);
`endif

endmodule

// File: tb/tb_axicb_id_order_ctrl.sv
// Directed bench for axicb_id_order_ctrl: scoreboard of expected accepts plus immediate-assert checks.
module tb_axicb_id_order_ctrl;

  logic       aclk;
  logic       srst;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_id;
  logic [3:0] s_ix;
  logic       m_valid;
  logic       m_ready;
  logic       c_done;
  logic [7:0] c_id;
  logic       busy;
  logic       err_uflow;
  logic       err_tmo;

  int         n_chk;
  int         n_fail;
  logic [7:0] exp_q [$];

  axicb_id_order_ctrl #(
    .AXI_ID_W    (8),
    .SLV_NB      (4),
    .NB_ID       (4),
    .MAX_OSTD    (4),
    .MST_ID_MASK (8'h00),
    .TMO_W       (4)
  ) dut (
    .aclk      (aclk),
    .srst      (srst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_id      (s_id),
    .s_ix      (s_ix),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .c_done    (c_done),
    .c_id      (c_id),
    .busy      (busy),
    .err_uflow (err_uflow),
    .err_tmo   (err_tmo)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs just after the falling edge, then let the combinational outputs settle.
  task automatic apply(input logic v, input logic [7:0] id, input logic [3:0] ix,
                       input logic mr, input logic cd, input logic [7:0] cid, input logic exp_acc);
    s_valid = v;
    s_id    = id;
    s_ix    = ix;
    m_ready = mr;
    c_done  = cd;
    c_id    = cid;
    if (exp_acc) exp_q.push_back(id);
    #2;
  endtask

  // Score any handshake of this cycle against the queue, then move to the next falling edge.
  task automatic next();
    logic [7:0] e;
    if (s_valid && s_ready && m_valid) begin
      n_chk++;
      assert (exp_q.size() > 0) else begin
        n_fail++;
        $error("FAIL sb_unexpected: observed accept of id %0h expected no accept", s_id);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_id", {24'b0, s_id}, {24'b0, e});
      end
    end
    @(negedge aclk);
  endtask

  initial begin
    logic [7:0] drain_ids [8];
    logic       tmo_exp;
    n_chk  = 0;
    n_fail = 0;
    drain_ids = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd2, 8'd2, 8'd2, 8'd3};
`ifdef AXICB_ORDER_TMO_EN
    tmo_exp = 1'b1;
`else
    tmo_exp = 1'b0;
`endif
    srst = 1'b1;
    s_valid = 1'b0; s_id = '0; s_ix = 4'b0001; m_ready = 1'b0; c_done = 1'b0; c_id = '0;
    @(negedge aclk);

    // Reset: transparent gating, everything cleared
    apply(1, 8'd0, 4'b0001, 0, 0, 8'd0, 0);
    chk("rst_m_valid", m_valid, 1);
    chk("rst_s_ready_lo", s_ready, 0);
    next();
    apply(0, 8'd0, 4'b0001, 1, 0, 8'd0, 0);
    chk("rst_s_ready_hi", s_ready, 1);
    chk("rst_m_valid_lo", m_valid, 0);
    next();
    srst = 1'b0;
    apply(0, 8'd0, 4'b0001, 1, 0, 8'd0, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_uflow", err_uflow, 0);
    chk("rst_err_tmo", err_tmo, 0);
    next();

    // 1: first request passes in the same cycle, busy follows
    apply(1, 8'd0, 4'b0001, 1, 0, 8'd0, 1);
    chk("t1_m_valid", m_valid, 1);
    chk("t1_s_ready", s_ready, 1);
    chk("t1_busy_before", busy, 0);
    next();
    apply(0, 8'd0, 4'b0001, 1, 0, 8'd0, 0);
    chk("t1_busy_after", busy, 1);
    next();

    // 2: same ID to another slave stalls until retired
    apply(1, 8'd1, 4'b0001, 1, 0, 8'd0, 1);
    next();
    for (int i = 0; i < 3; i++) begin
      apply(1, 8'd1, 4'b0010, 1, 0, 8'd0, 0);
      chk("t2_stall_m_valid", m_valid, 0);
      chk("t2_stall_s_ready", s_ready, 0);
      next();
    end
    apply(1, 8'd1, 4'b0010, 1, 1, 8'd1, 0);
    chk("t2_retire_cycle", m_valid, 0);
    next();
    apply(1, 8'd1, 4'b0010, 1, 0, 8'd0, 1);
    chk("t2_released", m_valid, 1);
    next();

    // ID index is taken modulo NB_ID: 0x15 and 0x05 share slot 1
    apply(1, 8'h15, 4'b0010, 1, 0, 8'd0, 1);
    chk("alias_same_slave", m_valid, 1);
    next();
    apply(1, 8'h05, 4'b0100, 1, 0, 8'd0, 0);
    chk("alias_other_slave", m_valid, 0);
    next();

    // 3: outstanding cap, no same-cycle bypass on release
    for (int i = 0; i < 4; i++) begin
      apply(1, 8'd2, 4'b0100, 1, 0, 8'd0, 1);
      chk("t3_fill", m_valid, 1);
      next();
    end
    apply(1, 8'd2, 4'b0100, 1, 0, 8'd0, 0);
    chk("t3_full_m_valid", m_valid, 0);
    chk("t3_full_s_ready", s_ready, 0);
    next();
    apply(1, 8'd2, 4'b0100, 1, 1, 8'd2, 0);
    chk("t3_no_bypass", m_valid, 0);
    next();
    apply(1, 8'd2, 4'b0100, 1, 0, 8'd0, 1);
    chk("t3_fifth_pass", m_valid, 1);
    next();

    // 4: accept and retire on the same ID in one cycle leave the count unchanged
    apply(1, 8'd3, 4'b1000, 1, 0, 8'd0, 1);
    next();
    apply(1, 8'd3, 4'b1000, 1, 1, 8'd3, 1);
    chk("t4_collide_pass", m_valid, 1);
    next();
    apply(1, 8'd3, 4'b0001, 1, 0, 8'd0, 0);
    chk("t4_cnt_kept", m_valid, 0);
    chk("t4_busy", busy, 1);
    next();
    apply(0, 8'd0, 4'b0001, 1, 1, 8'd3, 0);
    next();
    apply(1, 8'd3, 4'b0001, 1, 0, 8'd0, 1);
    chk("t4_freed", m_valid, 1);
    next();

    // Drain all outstanding: busy drops only after the last retire
    for (int i = 0; i < 8; i++) begin
      apply(0, 8'd0, 4'b0001, 1, 1, drain_ids[i], 0);
      if (i == 7) chk("drain_busy_last", busy, 1);
      next();
    end
    apply(0, 8'd0, 4'b0001, 1, 0, 8'd0, 0);
    chk("drain_busy", busy, 0);
    chk("drain_no_uflow", err_uflow, 0);
    next();

    // 5: underflow is sticky and does not wrap the counter; reset mid-traffic clears
    apply(0, 8'd0, 4'b0001, 1, 1, 8'd0, 0);
    next();
    apply(0, 8'd0, 4'b0001, 1, 0, 8'd0, 0);
    chk("t5_uflow", err_uflow, 1);
    chk("t5_busy", busy, 0);
    next();
    apply(1, 8'd0, 4'b0010, 1, 0, 8'd0, 1);
    chk("t5_no_wrap", m_valid, 1);
    next();
    apply(1, 8'd1, 4'b0001, 1, 0, 8'd0, 1);
    next();
    apply(1, 8'd1, 4'b0001, 1, 0, 8'd0, 1);
    next();
    srst = 1'b1;
    apply(1, 8'd1, 4'b0010, 0, 0, 8'd0, 0);
    chk("t5_rst_m_valid", m_valid, 1);
    chk("t5_rst_uflow_held", err_uflow, 1);
    next();
    srst = 1'b0;
    apply(0, 8'd0, 4'b0001, 1, 0, 8'd0, 0);
    chk("t5_rst_uflow", err_uflow, 0);
    chk("t5_rst_busy", busy, 0);
    next();
    apply(1, 8'd1, 4'b0010, 1, 0, 8'd0, 1);
    chk("t5_rst_owner1", m_valid, 1);
    next();
    apply(1, 8'd0, 4'b0001, 1, 0, 8'd0, 1);
    chk("t5_rst_owner0", m_valid, 1);
    next();

    // 6: stall timeout after 15 stalled cycles
    for (int i = 0; i < 14; i++) begin
      apply(1, 8'd0, 4'b0010, 1, 0, 8'd0, 0);
      if (i == 0) chk("t6_stalled", m_valid, 0);
      next();
    end
    apply(1, 8'd0, 4'b0010, 1, 0, 8'd0, 0);
    chk("t6_tmo_early", err_tmo, 0);
    next();
    apply(0, 8'd0, 4'b0001, 1, 1, 8'd0, 0);
    chk("t6_tmo", err_tmo, tmo_exp);
    next();
    apply(0, 8'd0, 4'b0001, 1, 1, 8'd1, 0);
    next();
    apply(0, 8'd0, 4'b0001, 1, 0, 8'd0, 0);
    chk("t6_tmo_sticky", err_tmo, tmo_exp);
    chk("t6_busy", busy, 0);
    next();

    chk("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
